// File: rtl/gpt_output_compare_if.sv
// Time-base and CCRx write bundle feeding one GPT output-compare channel.
// The time base and regblock drive it (master); the channel consumes it (slave).
interface gpt_output_compare_if #(
  parameter int CNT_WIDTH = 32
);
  logic [CNT_WIDTH-1:0] cnt_i;
  logic                 cnt_tick_i;
  logic                 dir_i;
  logic                 uev_i;
  logic [CNT_WIDTH-1:0] ccr_wdata_i;
  logic                 ccr_we_i;

  modport master (
    output cnt_i, cnt_tick_i, dir_i, uev_i, ccr_wdata_i, ccr_we_i
  );

  modport slave (
    input cnt_i, cnt_tick_i, dir_i, uev_i, ccr_wdata_i, ccr_we_i
  );
endinterface

// File: rtl/gpt_output_compare.sv
// One GPT output-compare/PWM channel: preloaded CCRx, OCxREF generation,
// OCxREF clear latch, compare-match pulse and CCxIF flag.
module gpt_output_compare #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk_i,
  input  logic                 aresetn_i,
  gpt_output_compare_if.slave  cnt_bus,
  input  logic [2:0]           ocm_i,
  input  logic                 ocpe_i,
  input  logic                 occe_i,
  input  logic                 ocref_clr_i,
  input  logic                 ccp_i,
  input  logic                 cce_i,
  input  logic                 ccg_i,
  input  logic                 ccif_clr_i,
  output logic [CNT_WIDTH-1:0] ccr_o,
  output logic                 ocref_o,
  output logic                 oc_o,
  output logic                 match_o,
  output logic                 ccif_o
);

  typedef enum logic [2:0] {
    OC_FROZEN  = 3'b000,
    OC_SET     = 3'b001,
    OC_CLEAR   = 3'b010,
    OC_TOGGLE  = 3'b011,
    OC_FORCE_0 = 3'b100,
    OC_FORCE_1 = 3'b101,
    OC_PWM1    = 3'b110,
    OC_PWM2    = 3'b111
  } oc_mode_e;

  oc_mode_e             mode;
  logic [CNT_WIDTH-1:0] ccr_pre;
  logic                 clr_latch;
  logic                 clr_latch_nxt;
  logic                 match_evt;
  logic                 pwm1_lvl;
  logic                 ocref_nxt;

  assign mode      = oc_mode_e'(ocm_i);
  assign match_evt = cnt_bus.cnt_tick_i & (cnt_bus.cnt_i == ccr_o);

  // PWM1 level, evaluated every cycle with unsigned full-width compares.
  assign pwm1_lvl = cnt_bus.dir_i ? !(cnt_bus.cnt_i > ccr_o)
                                  :  (cnt_bus.cnt_i < ccr_o);

  // Set has priority; release only on an update event with the request gone.
  always_comb begin
    clr_latch_nxt = clr_latch;
    if (occe_i && ocref_clr_i)
      clr_latch_nxt = 1'b1;
    else if (cnt_bus.uev_i && !ocref_clr_i)
      clr_latch_nxt = 1'b0;
  end

  // Using the next latch value lets a clear request force OCxREF low one cycle later.
  always_comb begin
    ocref_nxt = ocref_o;
    case (mode)
      OC_FROZEN:  ocref_nxt = ocref_o;
      OC_SET:     if (match_evt) ocref_nxt = 1'b1;
      OC_CLEAR:   if (match_evt) ocref_nxt = 1'b0;
      OC_TOGGLE:  if (match_evt) ocref_nxt = ~ocref_o;
      OC_FORCE_0: ocref_nxt = 1'b0;
      OC_FORCE_1: ocref_nxt = 1'b1;
      OC_PWM1:    ocref_nxt = pwm1_lvl;
      OC_PWM2:    ocref_nxt = ~pwm1_lvl;
      default:    ocref_nxt = ocref_o;
    endcase
    if (clr_latch_nxt)
      ocref_nxt = 1'b0;
  end

  // With preload on, a write and UEV in the same cycle move the old preload to the shadow.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      ccr_pre <= '0;
      ccr_o   <= '0;
    end else begin
      if (cnt_bus.ccr_we_i)
        ccr_pre <= cnt_bus.ccr_wdata_i;
      if (cnt_bus.ccr_we_i && !ocpe_i)
        ccr_o <= cnt_bus.ccr_wdata_i;
      else if (cnt_bus.uev_i && ocpe_i)
        ccr_o <= ccr_pre;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      clr_latch <= 1'b0;
      ocref_o   <= 1'b0;
      match_o   <= 1'b0;
      ccif_o    <= 1'b0;
    end else begin
      clr_latch <= clr_latch_nxt;
      ocref_o   <= ocref_nxt;
      match_o   <= match_evt;
      if (match_evt || ccg_i)
        ccif_o <= 1'b1;
      else if (ccif_clr_i)
        ccif_o <= 1'b0;
    end
  end

  assign oc_o = cce_i ? (ocref_o ^ ccp_i) : 1'b0;

endmodule

// File: doc/gpt_output_compare.md
Name: gpt_output_compare

Overview:
- One output-compare/PWM channel for the general-purpose timer; GPT top instantiates one per channel.
- Sits directly downstream of the time-base counter: consumes its count value, direction, tick and update event (UEV).
- Produces the OCxREF reference, the polarity/enable-gated OCx pin drive, a compare-match pulse and the CCxIF flag.
- Holds the preloaded/active capture-compare register (CCRx).

Parameters:
CNT_WIDTH, 32, width of counter and CCR values

Ports:
aclk_i  input  1  timer clock
aresetn_i  input  1  asynchronous active-low reset
cnt_i  input  CNT_WIDTH  current counter value from time base
cnt_tick_i  input  1  cnt_i took a new value this cycle
dir_i  input  1  count direction: 0 up, 1 down
uev_i  input  1  update event pulse from time base
ccr_wdata_i  input  CNT_WIDTH  CCRx write data from regblock
ccr_we_i  input  1  CCRx write strobe
ocm_i  input  3  OCxM output compare mode
ocpe_i  input  1  CCRx preload enable
occe_i  input  1  OCxREF clear enable
ocref_clr_i  input  1  external OCxREF clear request (level)
ccp_i  input  1  output polarity: 1 = active low
cce_i  input  1  channel output enable
ccg_i  input  1  software compare-generate pulse (EGR.CCxG)
ccif_clr_i  input  1  CCxIF clear strobe
ccr_o  output  CNT_WIDTH  active (shadow) CCRx value
ocref_o  output  1  OCxREF
oc_o  output  1  OCx pin drive
match_o  output  1  one-cycle compare-match pulse
ccif_o  output  1  CCxIF status flag

Behaviour:
- Reset (async assert, sync release): ccr_pre=0, ccr_o=0, ocref_o=0, match_o=0, ccif_o=0, clear latch=0; oc_o=0.
- CCR write, ocpe_i=0: ccr_o <= ccr_wdata_i next cycle; preload also written.
- CCR write, ocpe_i=1: only ccr_pre written. On uev_i, ccr_o <= ccr_pre.
- Simultaneous write and uev_i with ocpe_i=1: ccr_o takes the old ccr_pre; ccr_pre takes the new data.
- match_evt = cnt_tick_i & (cnt_i == ccr_o). match_o is registered: asserted 1 cycle after match_evt, for 1 cycle.
- ccif_o:
  - Set on match_evt or ccg_i.
  - Cleared by ccif_clr_i.
  - Set wins over a simultaneous clear.
- Clear latch:
  - Set when occe_i & ocref_clr_i.
  - Cleared on the first uev_i with ocref_clr_i low.
  - While set, ocref_o is forced to 0, overriding every mode.
- ocref_o next-state (registered, 1-cycle latency), by ocm_i:
  - 000 frozen: hold.
  - 001: set to 1 on match_evt.
  - 010: set to 0 on match_evt.
  - 011: toggle on match_evt.
  - 100: force 0.
  - 101: force 1.
  - 110 PWM1: up-count → 1 iff cnt_i < ccr_o; down-count → 0 iff cnt_i > ccr_o, else 1.
  - 111 PWM2: inverse of PWM1.
- PWM evaluation details:
  - PWM is evaluated every cycle, not only on ticks.
  - Compares are unsigned, full CNT_WIDTH.
  - ccr_o=0 in PWM1 up-count gives constant 0.
  - ccr_o above the auto-reload value gives constant 1.
- ccg_i does not change ocref_o; it only sets ccif_o.
- Mode changes take effect on the next cycle. Switching to frozen retains the current ocref_o.
- oc_o is combinational from registered state: cce_i ? (ocref_o ^ ccp_i) : 0.

Test Plan:
- ocpe=0, write CCR=5, ocm=011, counter 0..9 up with tick each cycle → ccr_o=5 next cycle; match_o pulses the cycle after cnt=5; ocref_o toggles 0→1 then; ccif_o=1.
- ocpe=1, write CCR=7 while ccr_o=3, then uev_i → ccr_o stays 3 until uev_i, 7 the cycle after. Write 9 in the same cycle as a uev → ccr_o=7, ccr_pre=9.
- ocm=110, CCR=4, up-count 0..9 → ocref_o=1 for cnt 0..3, 0 for 4..9. Down-count 9..0 → ocref_o=0 for 9..5, 1 for 4..0. CCR=0 up → constant 0.
- PWM1 running, occe=1, pulse ocref_clr_i 1 cycle mid-period → ocref_o=0 next cycle, held until the next uev_i, then PWM resumes.
- ccif_clr_i and match_evt in the same cycle → ccif_o stays 1. ccg_i alone → ccif_o=1 and ocref_o unchanged.
- ocm=101, ccp=1, toggle cce 1→0 → oc_o=0 then 0 (ocref_o=1). Assert aresetn_i low mid-PWM → all outputs 0 immediately.
